// File: rtl/img_proc_pkg.sv
// img_proc_pkg: pixel, high-pass and window types shared by the sharpening pipeline
package img_proc_pkg;
   localparam int PIX_W = 8;
   localparam int OUT_W = 21;
   typedef logic [PIX_W-1:0] pix_t;
   typedef logic signed [OUT_W-1:0] hp_t;
   typedef pix_t [0:2][0:2] win_t;
endpackage

// File: rtl/laplacian_window_if.sv
// laplacian_window_if: raster pixel stream in, Laplacian term plus aligned centre out
interface laplacian_window_if;
   import img_proc_pkg::*;
   logic           stall;
   logic           pix_valid;
   pix_t           pix_in;
   hp_t            sharpened_image;
   logic [PIX_W:0] img;
   logic           out_valid;
   modport master (output stall, pix_valid, pix_in, input sharpened_image, img, out_valid);
   modport slave  (input stall, pix_valid, pix_in, output sharpened_image, img, out_valid);
endinterface

// File: rtl/line_buffer.sv
// line_buffer: one image row of pixels; the read returns the old value in the cycle it is overwritten
module line_buffer
   import img_proc_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  pix_t                     wdata,
   output pix_t                     rdata
);
   pix_t mem_q [DEPTH];
   assign rdata = mem_q[addr];
   always_ff @(posedge clk)
      if (en) mem_q[addr] <= wdata;
endmodule

// File: rtl/laplacian_window.sv
// laplacian_window: streaming 3x3 Laplacian feeding the sharpening adder.
// Define LAPLACE_DIAG_EN for the 8-neighbour kernel; default is the 4-neighbour kernel.
module laplacian_window
   import img_proc_pkg::*;
#(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256
) (
   input logic               clk,
   input logic               reset,
   laplacian_window_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   win_t          win_q, win_d;
   logic          v1_q, v1_d, ov_q, ov_d;
   hp_t           hp_q, hp_d;
   pix_t          img_q, img_d;
   pix_t          lb0_rd, lb1_rd;
   logic          accept;
   function automatic hp_t lap(input win_t w);
      int s;
`ifdef LAPLACE_DIAG_EN
      s = 9 * int'(w[1][1]);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            s -= int'(w[r][c]);
`else
      s = 4 * int'(w[1][1]) - int'(w[0][1]) - int'(w[2][1]) - int'(w[1][0]) - int'(w[1][2]);
`endif
      return hp_t'(s);
   endfunction
   assign accept = bus.pix_valid & ~bus.stall;
   // lb1 receives the row that lb0 is about to lose, so the two buffers hold rows r-2 and r-1
   line_buffer #(.DEPTH(IMG_W)) lb0 (.clk(clk), .en(accept), .addr(col_q), .wdata(bus.pix_in), .rdata(lb0_rd));
   line_buffer #(.DEPTH(IMG_W)) lb1 (.clk(clk), .en(accept), .addr(col_q), .wdata(lb0_rd),     .rdata(lb1_rd));
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      win_d = win_q;
      v1_d  = v1_q;
      ov_d  = ov_q;
      hp_d  = hp_q;
      img_d = img_q;
      if (!bus.stall) begin
         v1_d  = accept && row_q >= RW'(2) && col_q >= CW'(2);
         ov_d  = v1_q;
         hp_d  = v1_q ? lap(win_q) : hp_q;
         img_d = v1_q ? win_q[1][1] : img_q;
      end
      if (accept) begin
         col_d = col_q == CW'(IMG_W - 1) ? '0 : col_q + CW'(1);
         row_d = col_q != CW'(IMG_W - 1) ? row_q : row_q == RW'(IMG_H - 1) ? '0 : row_q + RW'(1);
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_rd;
         win_d[1][2] = lb0_rd;
         win_d[2][2] = bus.pix_in;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
         win_q <= '0;
         v1_q  <= 1'b0;
         ov_q  <= 1'b0;
         hp_q  <= '0;
         img_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         win_q <= win_d;
         v1_q  <= v1_d;
         ov_q  <= ov_d;
         hp_q  <= hp_d;
         img_q <= img_d;
      end
   end
   assign bus.sharpened_image = hp_q;
   assign bus.img             = {1'b0, img_q};
   assign bus.out_valid       = ov_q;
endmodule

// File: tb/tb_laplacian_window.sv
// tb_laplacian_window: random-timed frames checked against a per-pixel Laplacian reference
module tb_laplacian_window;
   import img_proc_pkg::*;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int NI = (W - 2) * (H - 2);
`ifdef LAPLACE_DIAG_EN
   localparam int K_C = 1600, K_D = -200;
`else
   localparam int K_C = 800, K_D = 0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   laplacian_window_if bus ();
   laplacian_window #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   int n_cmp = 0;
   int n_bad = 0;
   int seen = 0;
   int k_mon;
   int frame [H][W];
   int rec_hp [H][W];
   int rec_img [H][W];
   int exp_hp [$];
   int exp_img [$];
   hp_t snap_hp;
   logic [PIX_W:0] snap_img;
   logic snap_ov;
   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic int ref_hp(input int r, input int c);
      int s = 0;
`ifdef LAPLACE_DIAG_EN
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) s += frame[r][c] - frame[r+dr][c+dc];
`else
      s = 4 * frame[r][c] - frame[r-1][c] - frame[r+1][c] - frame[r][c-1] - frame[r][c+1];
`endif
      return s;
   endfunction
   function automatic void push_expected();
      for (int r = 1; r < H - 1; r++)
         for (int c = 1; c < W - 1; c++) begin
            exp_hp.push_back(ref_hp(r, c));
            exp_img.push_back(frame[r][c]);
         end
   endfunction
   function automatic void fill(input int v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            frame[r][c] = v;
   endfunction
   task automatic send(input int npix, input int stall_pct, input int gap_pct, input bit hold3);
      int i = 0;
      int held = 0;
      while (i < npix) begin
         @(negedge clk);
         bus.pix_in = pix_t'(frame[i / W][i % W]);
         if (hold3 && i == 4 * W + 3 && held < 3) begin
            bus.stall = 1'b1;
            bus.pix_valid = 1'b1;
            held++;
         end else begin
            bus.stall = $urandom_range(99) < stall_pct;
            bus.pix_valid = $urandom_range(99) >= gap_pct;
         end
         if (bus.pix_valid && !bus.stall) i++;
      end
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.pix_valid = 1'b0;
         bus.stall = 1'b0;
      end
   endtask
   task automatic run(input string name, input int sp, input int gp, input bit h3);
      seen = 0;
      push_expected();
      send(W * H, sp, gp, h3);
      idle(4);
      check({name, "_count"}, seen, NI);
      check({name, "_left"}, exp_hp.size(), 0);
   endtask
   task automatic impulse_checks(input string name);
      check({name, "_c"}, rec_hp[4][4], K_C);
      check({name, "_cimg"}, rec_img[4][4], 200);
      check({name, "_n"}, rec_hp[3][4], -200);
      check({name, "_s"}, rec_hp[5][4], -200);
      check({name, "_w"}, rec_hp[4][3], -200);
      check({name, "_e"}, rec_hp[4][5], -200);
      check({name, "_d"}, rec_hp[3][3], K_D);
   endtask
   always @(posedge clk) begin
      #1;
      if (reset) begin
         check("rst_ov", bus.out_valid, 0);
         check("rst_hp", bus.sharpened_image, 0);
         check("rst_img", bus.img, 0);
      end else if (bus.stall) begin
         check("stall_ov", bus.out_valid, snap_ov);
         check("stall_hp", bus.sharpened_image, snap_hp);
         check("stall_img", bus.img, snap_img);
      end else if (bus.out_valid) begin
         if (exp_hp.size() == 0) check("extra_out", 1, 0);
         else begin
            k_mon = seen % NI;
            rec_hp[1 + k_mon / (W - 2)][1 + k_mon % (W - 2)] = int'(bus.sharpened_image);
            rec_img[1 + k_mon / (W - 2)][1 + k_mon % (W - 2)] = int'(bus.img);
            check("hp", bus.sharpened_image, exp_hp.pop_front());
            check("img", bus.img, exp_img.pop_front());
         end
         seen++;
      end else begin
         check("hold_hp", bus.sharpened_image, snap_hp);
         check("hold_img", bus.img, snap_img);
      end
      snap_ov = bus.out_valid;
      snap_hp = bus.sharpened_image;
      snap_img = bus.img;
   end
   initial begin
      bus.stall = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_in = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      fill(100);
      run("flat", 0, 0, 1'b0);
      fill(0);
      frame[4][4] = 200;
      run("imp", 0, 0, 1'b0);
      impulse_checks("imp");
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            frame[r][c] = 30 * c;
      run("ramp", 0, 0, 1'b0);
      fill(0);
      frame[4][4] = 200;
      run("imp_stall", 20, 20, 1'b1);
      impulse_checks("imp_stall");
      fill(100);
      seen = 0;
      push_expected();
      send(20, 0, 0, 1'b0);
      idle(2);
      check("partial_count", seen, 2);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_hp.delete();
      exp_img.delete();
      run("after_rst", 0, 0, 1'b0);
      seen = 0;
      fill(50);
      push_expected();
      send(W * H, 0, 0, 1'b0);
      fill(250);
      push_expected();
      send(W * H, 0, 0, 1'b0);
      idle(4);
      check("b2b_count", seen, 2 * NI);
      check("b2b_left", exp_hp.size(), 0);
      check("b2b_last_img", rec_img[H-2][W-2], 250);
      for (int t = 0; t < 4; t++) begin
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               frame[r][c] = t[0] ? ($urandom_range(1) != 0 ? 255 : 0) : int'($urandom_range(255));
         run("rand", 25, 25, 1'b0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/laplacian_window.md
Name: laplacian_window

Overview:
- Streaming 3x3 Laplacian stage, directly upstream of the sharpening adder.
- Accepts raster-order 8-bit pixels, one per accepted cycle.
- Keeps two line buffers and a 3x3 window.
- Emits the signed high-pass term on sharpened_image plus the matching, aligned centre pixel on img, so the adder forms centre + Laplacian.

Parameters:
- IMG_W, 256, pixels per row; must be >= 3.
- IMG_H, 256, rows per frame; must be >= 3.
- PIX_W, 8, input pixel width.
- OUT_W, 21, signed width of sharpened_image.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freezes all state and outputs while high; shared with the downstream adder.
- pix_in  in  PIX_W  unsigned raster pixel.
- pix_valid  in  1  pix_in valid this cycle.
- sharpened_image  out  OUT_W  signed Laplacian of the window centre.
- img  out  PIX_W+1  window centre pixel, zero-extended to 9 bits.
- out_valid  out  1  sharpened_image and img valid.

Behaviour:
- Reset (reset=1 at a clk edge):
  - col=0, row=0, stage-2 valid=0.
  - sharpened_image=0, img=0, out_valid=0.
  - Window registers cleared to 0.
  - Line-buffer contents are don't-care.
  - Reset mid-frame drops the partial frame; the next accepted pixel is (0,0).
- Accept condition: accept = pix_valid & ~stall.
- stall=1 overrides everything:
  - No counter, line-buffer, window or output register changes.
  - pix_in is ignored; upstream must hold it.
- Stage 1, on accept:
  - lb1[col] <= lb0[col] (old value); lb0[col] <= pix_in.
  - Window shifts left one column. New right column is top=lb1[col], mid=lb0[col], bot=pix_in, using pre-write values for lb reads.
  - Stage-1 valid = (row>=2 && col>=2). Window centre is then pixel (row-1, col-1).
  - Counter update: col increments; at col=IMG_W-1, col wraps to 0 and row increments.
  - At row=IMG_H-1 with col=IMG_W-1, row wraps to 0 (frame boundary). No idle cycle is needed between frames.
- Stage 1, no accept with stall=0: stage-1 valid=0; window and counters hold.
- Stage 2 (output registers), on stall=0:
  - out_valid <= stage-1 valid.
  - img <= {1'b0, centre}.
  - sharpened_image <= 4*C - N - S - E - W, computed signed and sign-extended to OUT_W. Range is -1020..+1020.
  - When stage-1 valid=0, sharpened_image and img hold their previous values; only out_valid drops.
- Latency: output for centre (r-1, c-1) appears 1 cycle after input (r,c) is accepted, plus one cycle per stall cycle in between.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) are never emitted. Each frame yields exactly (IMG_W-2)*(IMG_H-2) outputs.
- Simultaneous reset and stall: reset wins.

Optional Feature:
- Macro: LAPLACE_DIAG_EN.
- Defined: 8-neighbour kernel, sharpened_image = 8*C - sum of all 8 neighbours. Range is -2040..+2040, still OUT_W. Latency and valid timing unchanged.
- Undefined: 4-neighbour kernel as described above.

Decomposition:
- Package img_proc_pkg:
  - Constants PIX_W=8 and OUT_W=21.
  - Typedef pix_t (logic [PIX_W-1:0]).
  - Typedef hp_t (logic signed [OUT_W-1:0]).
  - Typedef win_t (3x3 array of pix_t).
- One sub-module: line_buffer.
  - Depth IMG_W, width PIX_W.
  - Single address port, read-old-then-write on enable.
  - Instantiated twice (lb0, lb1).

Test Plan:
- IMG_W=IMG_H=8, flat frame of all pixels = 100, no stalls:
  - Exactly 36 outputs.
  - Every output has sharpened_image=0 and img=100.
- 8x8 frame of zeros with 200 at (4,4):
  - Centre (4,4) -> +800, img=200.
  - (3,4), (5,4), (4,3), (4,5) -> -200.
  - (3,3) -> 0 (-200 with LAPLACE_DIAG_EN, and centre -> +1600).
- Horizontal ramp, pixel = 30*col: all outputs have sharpened_image=0, and img equals 30*(col-1) for the accepted column.
- Same impulse frame, stall held for 3 cycles mid-row 4 and pix_valid gaps inserted:
  - Output sequence identical to the no-stall run.
  - Outputs constant during the stall; no duplicates or drops.
- Reset asserted after 20 accepted pixels, then a fresh flat-100 frame:
  - out_valid=0 the cycle after reset.
  - Output count restarts at 36, all values 0/100.
- Two back-to-back 8x8 frames (frame 1 all 50, frame 2 all 250) with pix_valid continuous:
  - 72 outputs total.
  - First 36 have img=50, last 36 have img=250; all sharpened_image=0.
